// File: rtl/i2c_reg_seq.sv
// ---------------------------------------------------------------------------
// i2c_reg_seq
// Register-level sequencer sitting in front of a byte-level I2C master.
// One accepted request becomes the command sequence
//   write: START, WRITE {dev,0}, WRITE reg, WRITE data, STOP
//   read : START, WRITE {dev,0}, WRITE reg, START, WRITE {dev,1}, READ(NAK), STOP
// Each command is issued with a one-cycle strobe. The sequencer then waits for
// the master to return to ready, checks the slave ACK and captures read data.
// A slave NAK on any WRITE step jumps straight to the STOP step so the bus is
// always released.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   req, rw            request (sampled in IDLE), 0 = write / 1 = read
//   dev_addr, reg_addr, wdata   transaction operands, latched on accept
//   busy, done, nak, rdata      status towards the user
//   i2c_cmd, i2c_stb, i2c_data, i2c_ack   command interface to the master
//   i2c_data_out, i2c_ack_out, i2c_ready  response interface from the master
// ---------------------------------------------------------------------------
module i2c_reg_seq #(
    parameter int GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       nak,
    output logic [7:0] rdata,
    output logic [1:0] i2c_cmd,
    output logic       i2c_stb,
    output logic [7:0] i2c_data,
    output logic       i2c_ack,
    input  logic [7:0] i2c_data_out,
    input  logic       i2c_ack_out,
    input  logic       i2c_ready
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b11;
    // Last GAP count value; only reachable when GAP_CYCLES > 0.
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

    // {cmd, data, ack} presented to the master for a given step.
    function automatic logic [10:0] step_word(input logic       is_read,
                                              input logic [2:0] step,
                                              input logic [6:0] dev,
                                              input logic [7:0] reg_a,
                                              input logic [7:0] wd);
        logic [10:0] w;
        w = {CMD_STOP, 8'h00, 1'b0};
        if (is_read) begin
            case (step)
                3'd0:    w = {CMD_START, 8'h00, 1'b0};
                3'd1:    w = {CMD_WRITE, {dev, 1'b0}, 1'b0};
                3'd2:    w = {CMD_WRITE, reg_a, 1'b0};
                3'd3:    w = {CMD_START, 8'h00, 1'b0};
                3'd4:    w = {CMD_WRITE, {dev, 1'b1}, 1'b0};
                3'd5:    w = {CMD_READ, 8'h00, 1'b1};   // master NAKs the only byte
                default: w = {CMD_STOP, 8'h00, 1'b0};
            endcase
        end else begin
            case (step)
                3'd0:    w = {CMD_START, 8'h00, 1'b0};
                3'd1:    w = {CMD_WRITE, {dev, 1'b0}, 1'b0};
                3'd2:    w = {CMD_WRITE, reg_a, 1'b0};
                3'd3:    w = {CMD_WRITE, wd, 1'b0};
                default: w = {CMD_STOP, 8'h00, 1'b0};
            endcase
        end
        return w;
    endfunction

    // Index of the STOP step for each transaction type.
    function automatic logic [2:0] stop_step(input logic is_read);
        return is_read ? 3'd6 : 3'd4;
    endfunction

    state_t      state_r, state_s;
    logic [2:0]  step_r, step_s;
    logic [7:0]  gap_cnt_r, gap_cnt_s;
    logic        first_wait_r, first_wait_s;
    logic        rw_r, rw_s;
    logic [6:0]  dev_r, dev_s;
    logic [7:0]  reg_r, reg_s;
    logic [7:0]  wdata_r, wdata_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        nak_r, nak_s;
    logic [7:0]  rdata_r, rdata_s;
    logic [1:0]  cmd_r, cmd_s;
    logic        stb_r, stb_s;
    logic [7:0]  data_r, data_s;
    logic        ack_r, ack_s;

    // Next-state and next-output logic.
    always_comb begin
        state_s      = state_r;
        step_s       = step_r;
        gap_cnt_s    = gap_cnt_r;
        first_wait_s = first_wait_r;
        rw_s         = rw_r;
        dev_s        = dev_r;
        reg_s        = reg_r;
        wdata_s      = wdata_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        nak_s        = nak_r;
        rdata_s      = rdata_r;
        cmd_s        = cmd_r;
        stb_s        = 1'b0;
        data_s       = data_r;
        ack_s        = ack_r;

        case (state_r)
            ST_IDLE: begin
                if (req && i2c_ready) begin
                    rw_s    = rw;
                    dev_s   = dev_addr;
                    reg_s   = reg_addr;
                    wdata_s = wdata;
                    nak_s   = 1'b0;
                    busy_s  = 1'b1;
                    step_s  = 3'd0;
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // The master still shows ready in the cycle right after the
                // strobe, so the first WAIT cycle must not look at it.
                first_wait_s = 1'b1;
                state_s      = ST_WAIT;
            end
            ST_WAIT: begin
                if (first_wait_r) begin
                    first_wait_s = 1'b0;
                end else if (i2c_ready) begin
                    if (step_r == stop_step(rw_r)) begin
                        done_s  = 1'b1;
                        state_s = ST_FINISH;
                    end else begin
                        if ((cmd_r == CMD_WRITE) && i2c_ack_out) begin
                            nak_s  = 1'b1;
                            step_s = stop_step(rw_r);
                        end else begin
                            if (cmd_r == CMD_READ) begin
                                rdata_s = i2c_data_out;
                            end else begin
                                rdata_s = rdata_r;
                            end
                            step_s = step_r + 3'd1;
                        end
                        if (GAP_CYCLES > 0) begin
                            gap_cnt_s = 8'd0;
                            state_s   = ST_GAP;
                        end else begin
                            state_s   = ST_ISSUE;
                        end
                    end
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    gap_cnt_s = 8'd0;
                    state_s   = ST_ISSUE;
                end else begin
                    gap_cnt_s = gap_cnt_r + 8'd1;
                end
            end
            ST_FINISH: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Command fields are loaded as ISSUE is entered so they are registered
        // alongside the strobe; operands come from the next-cycle values so a
        // freshly accepted request already drives its own START.
        if (state_s == ST_ISSUE) begin
            stb_s                  = 1'b1;
            {cmd_s, data_s, ack_s} = step_word(rw_s, step_s, dev_s, reg_s, wdata_s);
        end else begin
            stb_s = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            step_r       <= 3'd0;
            gap_cnt_r    <= 8'd0;
            first_wait_r <= 1'b0;
            rw_r         <= 1'b0;
            dev_r        <= 7'd0;
            reg_r        <= 8'd0;
            wdata_r      <= 8'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            nak_r        <= 1'b0;
            rdata_r      <= 8'h00;
            cmd_r        <= 2'b00;
            stb_r        <= 1'b0;
            data_r       <= 8'h00;
            ack_r        <= 1'b0;
        end else begin
            state_r      <= state_s;
            step_r       <= step_s;
            gap_cnt_r    <= gap_cnt_s;
            first_wait_r <= first_wait_s;
            rw_r         <= rw_s;
            dev_r        <= dev_s;
            reg_r        <= reg_s;
            wdata_r      <= wdata_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            nak_r        <= nak_s;
            rdata_r      <= rdata_s;
            cmd_r        <= cmd_s;
            stb_r        <= stb_s;
            data_r       <= data_s;
            ack_r        <= ack_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign nak      = nak_r;
    assign rdata    = rdata_r;
    assign i2c_cmd  = cmd_r;
    assign i2c_stb  = stb_r;
    assign i2c_data = data_r;
    assign i2c_ack  = ack_r;

endmodule

// File: tb/tb_i2c_reg_seq.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_seq
// Directed bench for i2c_reg_seq. Two instances run side by side:
//   index 0 : GAP_CYCLES = 0
//   index 1 : GAP_CYCLES = 4
// A small behavioural I2C master per instance keeps ready high for one cycle
// after each strobe, drops it, stays busy a few cycles, then raises ready with
// the scripted ACK/data. Every strobe is logged for checking.
// ---------------------------------------------------------------------------
module tb_i2c_reg_seq;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req [2];
    logic       rw;
    logic [6:0] dev_addr;
    logic [7:0] reg_addr;
    logic [7:0] wdata;

    logic       busy [2];
    logic       done [2];
    logic       nak [2];
    logic [7:0] rdata [2];
    logic [1:0] cmd [2];
    logic       stb [2];
    logic [7:0] i2c_data [2];
    logic       i2c_ack [2];
    logic [7:0] data_out [2];
    logic       ack_out [2];
    logic       ready [2];

    i2c_reg_seq #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .rw(rw),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wdata(wdata),
        .busy(busy[0]), .done(done[0]), .nak(nak[0]), .rdata(rdata[0]),
        .i2c_cmd(cmd[0]), .i2c_stb(stb[0]), .i2c_data(i2c_data[0]), .i2c_ack(i2c_ack[0]),
        .i2c_data_out(data_out[0]), .i2c_ack_out(ack_out[0]), .i2c_ready(ready[0])
    );

    i2c_reg_seq #(.GAP_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .rw(rw),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wdata(wdata),
        .busy(busy[1]), .done(done[1]), .nak(nak[1]), .rdata(rdata[1]),
        .i2c_cmd(cmd[1]), .i2c_stb(stb[1]), .i2c_data(i2c_data[1]), .i2c_ack(i2c_ack[1]),
        .i2c_data_out(data_out[1]), .i2c_ack_out(ack_out[1]), .i2c_ready(ready[1])
    );

    int checks = 0;
    int errors = 0;

    // Master model state and strobe log.
    int         cyc = 0;
    int         nstb [2] = '{0, 0};
    int         ndone [2] = '{0, 0};
    int         base [2] = '{0, 0};
    logic       pend [2];
    int         cnt [2];
    logic [1:0] lcmd [2];
    int         rdy_cyc [2] = '{0, 0};
    logic [1:0] log_cmd [2][256];
    logic [7:0] log_data [2][256];
    logic       log_ack [2][256];
    int         log_gap [2][256];
    int         nak_idx = -1;      // strobe index within a transaction to NAK
    logic [7:0] rd_byte = 8'h00;

    // Behavioural byte-level master for both instances.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (done[i] === 1'b1) ndone[i] <= ndone[i] + 1;
            if (!rst_n) begin
                ready[i]    <= 1'b1;
                pend[i]     <= 1'b0;
                cnt[i]      <= 0;
                ack_out[i]  <= 1'b0;
                data_out[i] <= 8'h00;
                lcmd[i]     <= 2'b00;
            end else begin
                if (stb[i]) begin
                    pend[i]                 <= 1'b1;
                    lcmd[i]                 <= cmd[i];
                    log_cmd[i][nstb[i]]     <= cmd[i];
                    log_data[i][nstb[i]]    <= i2c_data[i];
                    log_ack[i][nstb[i]]     <= i2c_ack[i];
                    log_gap[i][nstb[i]]     <= cyc - rdy_cyc[i];
                    nstb[i]                 <= nstb[i] + 1;
                end
                if (pend[i]) begin
                    ready[i] <= 1'b0;
                    cnt[i]   <= 2;
                    pend[i]  <= 1'b0;
                end else if (!ready[i]) begin
                    if (cnt[i] == 0) begin
                        ready[i]    <= 1'b1;
                        rdy_cyc[i]  <= cyc;
                        data_out[i] <= rd_byte;
                        ack_out[i]  <= (lcmd[i] == 2'b10) && ((nstb[i] - 1 - base[i]) == nak_idx);
                    end else begin
                        cnt[i] <= cnt[i] - 1;
                    end
                end
            end
        end
    end

    task automatic start_txn(input int i, input logic r, input logic [6:0] d,
                             input logic [7:0] ra, input logic [7:0] wd);
        @(negedge clk);
        rw = r; dev_addr = d; reg_addr = ra; wdata = wd;
        base[i] = nstb[i];
        req[i] = 1'b1;
        @(negedge clk);
        req[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (done[i] === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({busy[i], done[i], nak[i], rdata[i], cmd[i], stb[i], i2c_data[i], i2c_ack[i]} !== 21'd0) begin
                errors++;
                $display("FAIL reset_outputs inst%0d got busy=%b done=%b nak=%b rdata=%h cmd=%b stb=%b data=%h ack=%b expected all zero",
                         i, busy[i], done[i], nak[i], rdata[i], cmd[i], stb[i], i2c_data[i], i2c_ack[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write();
        logic [1:0] ec [5] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b01};
        logic [7:0] ed [5] = '{8'h00, 8'h34, 8'h05, 8'hA5, 8'h00};
        bit ok;
        int d0;
        d0 = ndone[0];
        start_txn(0, 1'b0, 7'h1A, 8'h05, 8'hA5);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++; $display("FAIL write_busy_after_accept got %b expected 1", busy[0]);
        end
        wait_done(0, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL write_done_timeout got no done expected done");
        end
        checks++;
        if (nak[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++; $display("FAIL write_status_at_done got nak=%b busy=%b expected nak=0 busy=1", nak[0], busy[0]);
        end
        checks++;
        if (nstb[0] - base[0] !== 5) begin
            errors++; $display("FAIL write_strobe_count got %0d expected 5", nstb[0] - base[0]);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (log_cmd[0][base[0]+k] !== ec[k] || log_data[0][base[0]+k] !== ed[k] || log_ack[0][base[0]+k] !== 1'b0) begin
                errors++;
                $display("FAIL write_step%0d got cmd=%b data=%h ack=%b expected cmd=%b data=%h ack=0",
                         k, log_cmd[0][base[0]+k], log_data[0][base[0]+k], log_ack[0][base[0]+k], ec[k], ed[k]);
            end
            if (k > 0) begin
                checks++;
                if (log_gap[0][base[0]+k] !== 2) begin
                    errors++; $display("FAIL write_gap0_step%0d got %0d expected 2", k, log_gap[0][base[0]+k]);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL write_after_done got done=%b busy=%b expected 0 0", done[0], busy[0]);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (ndone[0] - d0 !== 1) begin
            errors++; $display("FAIL write_done_pulses got %0d expected 1", ndone[0] - d0);
        end
    endtask

    task automatic test_read();
        logic [1:0] ec [7] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b11, 2'b01};
        logic [7:0] ed [7] = '{8'h00, 8'h34, 8'h10, 8'h00, 8'h35, 8'h00, 8'h00};
        logic       ea [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bit ok;
        rd_byte = 8'h3C;
        start_txn(0, 1'b1, 7'h1A, 8'h10, 8'hEE);
        wait_done(0, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL read_done_timeout got no done expected done");
        end
        checks++;
        if (rdata[0] !== 8'h3C || nak[0] !== 1'b0) begin
            errors++; $display("FAIL read_result got rdata=%h nak=%b expected 3c 0", rdata[0], nak[0]);
        end
        checks++;
        if (nstb[0] - base[0] !== 7) begin
            errors++; $display("FAIL read_strobe_count got %0d expected 7", nstb[0] - base[0]);
        end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (log_cmd[0][base[0]+k] !== ec[k] || log_data[0][base[0]+k] !== ed[k] || log_ack[0][base[0]+k] !== ea[k]) begin
                errors++;
                $display("FAIL read_step%0d got cmd=%b data=%h ack=%b expected cmd=%b data=%h ack=%b",
                         k, log_cmd[0][base[0]+k], log_data[0][base[0]+k], log_ack[0][base[0]+k], ec[k], ed[k], ea[k]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_nak();
        logic [1:0] ec [3] = '{2'b00, 2'b10, 2'b01};
        logic [7:0] ed [3] = '{8'h00, 8'h34, 8'h00};
        bit ok;
        rd_byte = 8'h77;
        nak_idx = 1;
        start_txn(0, 1'b1, 7'h1A, 8'h10, 8'h00);
        wait_done(0, ok);
        nak_idx = -1;
        checks++;
        if (!ok) begin
            errors++; $display("FAIL nak_done_timeout got no done expected done");
        end
        checks++;
        if (nak[0] !== 1'b1 || rdata[0] !== 8'h3C) begin
            errors++; $display("FAIL nak_result got nak=%b rdata=%h expected 1 3c", nak[0], rdata[0]);
        end
        checks++;
        if (nstb[0] - base[0] !== 3) begin
            errors++; $display("FAIL nak_strobe_count got %0d expected 3", nstb[0] - base[0]);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (log_cmd[0][base[0]+k] !== ec[k] || log_data[0][base[0]+k] !== ed[k]) begin
                errors++;
                $display("FAIL nak_step%0d got cmd=%b data=%h expected cmd=%b data=%h",
                         k, log_cmd[0][base[0]+k], log_data[0][base[0]+k], ec[k], ed[k]);
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (nak[0] !== 1'b1) begin
            errors++; $display("FAIL nak_hold got %b expected 1", nak[0]);
        end
    endtask

    task automatic test_gap();
        logic [1:0] ec [5] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b01};
        logic [7:0] ed [5] = '{8'h00, 8'h34, 8'h5C, 8'h3E, 8'h00};
        bit ok;
        int d0;
        d0 = ndone[1];
        start_txn(1, 1'b0, 7'h1A, 8'h5C, 8'h3E);
        repeat (10) @(negedge clk);
        req[1] = 1'b1;            // request while busy must be dropped
        @(negedge clk);
        req[1] = 1'b0;
        wait_done(1, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL gap_done_timeout got no done expected done");
        end
        checks++;
        if (nstb[1] - base[1] !== 5) begin
            errors++; $display("FAIL gap_strobe_count got %0d expected 5", nstb[1] - base[1]);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (log_cmd[1][base[1]+k] !== ec[k] || log_data[1][base[1]+k] !== ed[k]) begin
                errors++;
                $display("FAIL gap_step%0d got cmd=%b data=%h expected cmd=%b data=%h",
                         k, log_cmd[1][base[1]+k], log_data[1][base[1]+k], ec[k], ed[k]);
            end
            if (k > 0) begin
                checks++;
                if (log_gap[1][base[1]+k] !== 6) begin
                    errors++; $display("FAIL gap4_step%0d got %0d expected 6", k, log_gap[1][base[1]+k]);
                end
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (ndone[1] - d0 !== 1 || nstb[1] - base[1] !== 5 || busy[1] !== 1'b0) begin
            errors++; $display("FAIL gap_no_queued_req got dones=%0d strobes=%0d busy=%b expected 1 5 0",
                               ndone[1] - d0, nstb[1] - base[1], busy[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] ec [5] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b01};
        logic [7:0] ed [5] = '{8'h00, 8'h56, 8'h44, 8'h81, 8'h00};
        bit ok;
        bit hit;
        int n;
        start_txn(0, 1'b0, 7'h1A, 8'h66, 8'h99);
        hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (nstb[0] - base[0] >= 3) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL rstmid_step2_timeout got %0d strobes expected 3", nstb[0] - base[0]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy[0], done[0], nak[0], rdata[0], cmd[0], stb[0], i2c_data[0], i2c_ack[0]} !== 21'd0) begin
            errors++;
            $display("FAIL rstmid_outputs got busy=%b done=%b nak=%b rdata=%h cmd=%b stb=%b data=%h ack=%b expected all zero",
                     busy[0], done[0], nak[0], rdata[0], cmd[0], stb[0], i2c_data[0], i2c_ack[0]);
        end
        rst_n = 1'b1;
        n = nstb[0];
        repeat (20) @(negedge clk);
        checks++;
        if (nstb[0] !== n || busy[0] !== 1'b0) begin
            errors++; $display("FAIL rstmid_no_stop got strobes=%0d busy=%b expected 0 0", nstb[0] - n, busy[0]);
        end
        start_txn(0, 1'b0, 7'h2B, 8'h44, 8'h81);
        wait_done(0, ok);
        checks++;
        if (!ok || nak[0] !== 1'b0 || nstb[0] - base[0] !== 5) begin
            errors++; $display("FAIL rstmid_clean_write got done=%b nak=%b strobes=%0d expected 1 0 5",
                               ok, nak[0], nstb[0] - base[0]);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (log_cmd[0][base[0]+k] !== ec[k] || log_data[0][base[0]+k] !== ed[k]) begin
                errors++;
                $display("FAIL rstmid_step%0d got cmd=%b data=%h expected cmd=%b data=%h",
                         k, log_cmd[0][base[0]+k], log_data[0][base[0]+k], ec[k], ed[k]);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [1:0] ec [7] = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b11, 2'b01};
        logic [7:0] ed [7] = '{8'h00, 8'h56, 8'h02, 8'h00, 8'h57, 8'h00, 8'h00};
        bit ok;
        int d0;
        d0 = ndone[0];
        @(negedge clk);
        rw = 1'b0; dev_addr = 7'h1A; reg_addr = 8'h01; wdata = 8'h11;
        base[0] = nstb[0];
        req[0] = 1'b1;
        wait_done(0, ok);
        checks++;
        if (!ok || nstb[0] - base[0] !== 5) begin
            errors++; $display("FAIL b2b_first got done=%b strobes=%0d expected 1 5", ok, nstb[0] - base[0]);
        end
        rw = 1'b1; dev_addr = 7'h2B; reg_addr = 8'h02; rd_byte = 8'h99;
        wait_done(0, ok);
        req[0] = 1'b0;
        checks++;
        if (!ok || nstb[0] - base[0] !== 12 || rdata[0] !== 8'h99) begin
            errors++; $display("FAIL b2b_second got done=%b strobes=%0d rdata=%h expected 1 12 99",
                               ok, nstb[0] - base[0], rdata[0]);
        end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (log_cmd[0][base[0]+5+k] !== ec[k] || log_data[0][base[0]+5+k] !== ed[k]) begin
                errors++;
                $display("FAIL b2b_step%0d got cmd=%b data=%h expected cmd=%b data=%h",
                         k, log_cmd[0][base[0]+5+k], log_data[0][base[0]+5+k], ec[k], ed[k]);
            end
        end
        repeat (10) @(negedge clk);
        checks++;
        if (ndone[0] - d0 !== 2 || busy[0] !== 1'b0 || nstb[0] - base[0] !== 12) begin
            errors++; $display("FAIL b2b_stop got dones=%0d busy=%b strobes=%0d expected 2 0 12",
                               ndone[0] - d0, busy[0], nstb[0] - base[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req[0] = 1'b0; req[1] = 1'b0;
        rw = 1'b0; dev_addr = 7'd0; reg_addr = 8'd0; wdata = 8'd0;
        test_reset();
        test_write();
        test_read();
        test_nak();
        test_gap();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

endmodule
